seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001: Parameters: none; all widths fixed.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: start  input  1  request a division; sampled only in IDLE.
REQ-005: dividend  input  8  unsigned dividend; sampled with start.
REQ-006: divisor  input  4  unsigned divisor; sampled with start.
REQ-007: busy  output  1  high while the block is in CALC.
REQ-008: done  output  1  single-cycle pulse; the result is valid.
REQ-009: quotient  output  8  unsigned quotient, registered.
REQ-010: remainder  output  4  unsigned remainder, registered.
REQ-011: div_zero  output  1  high when the last result came from a zero divisor; registered.

Function
REQ-012: The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013: IDLE with start=1 and divisor!=0 SHALL do the following at that edge (edge 0):
- latch dividend and divisor;
- clear the 5-bit partial remainder and the iteration counter;
- go to CALC.
REQ-014: IDLE with start=1 and divisor==0 SHALL do the following at edge 0:
- load quotient=8'hFF, remainder=4'h0 and div_zero=1;
- go directly to DONE.
REQ-015: CALC SHALL perform one restoring iteration per edge, MSB first, for exactly 8 edges:
- shift the next dividend bit into the partial remainder;
- trial-subtract the divisor zero-extended to 5 bits;
- if the result is non-negative, keep it and set the quotient bit to 1;
- otherwise restore the partial remainder and set the quotient bit to 0.
REQ-016: The iteration counter SHALL be 3 bits; the 8th CALC edge SHALL go to DONE.
REQ-017: On the 8th CALC edge, quotient and remainder SHALL be written and div_zero cleared to 0.
REQ-018: Quotient, remainder and div_zero SHALL NOT change on any other edge during CALC.
REQ-019: Latency SHALL be as follows:
- done is high in the cycle after edge 8 for a non-zero divisor;
- done is high in the cycle after edge 0 for a zero divisor.
REQ-020: done SHALL be 1 only in DONE; DONE SHALL always go to IDLE on the next edge.
REQ-021: busy SHALL be 1 only in CALC.
REQ-022: start SHALL be ignored in CALC and DONE; there is no queuing.
REQ-023: A start on the cycle right after DONE (back-to-back) SHALL be accepted normally.
REQ-024: Quotient, remainder and div_zero SHALL hold their last values until the next completion.
REQ-025: The remainder SHALL always be less than a non-zero divisor and fit in 4 bits.
REQ-026: dividend == quotient*divisor + remainder SHALL hold for every non-zero divisor.
REQ-027: Changes to the dividend/divisor inputs after edge 0 SHALL NOT affect the result in progress.

Reset
REQ-028: rst_n=0 SHALL immediately, independent of clk, do the following:
- force state to IDLE;
- clear busy, done, quotient, remainder, div_zero, the counter and the internal registers to 0.
REQ-029: Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-030: After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031: dividend=200, divisor=7, start pulse -> busy for 8 cycles, then done=1 for one cycle, quotient=28, remainder=4, div_zero=0.
REQ-032: 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 255/15 -> quotient=17, remainder=0.
REQ-033: dividend=100, divisor=0 -> done one cycle after start, busy never high, quotient=8'hFF, remainder=0, div_zero=1.
REQ-034: start held high during CALC with new operands (50/3) -> the first result (200/7 -> 28, 4) completes unchanged. A start in the cycle after done -> 50/3 gives 16, 2.
REQ-035: rst_n pulsed low at CALC cycle 4 -> all outputs 0 immediately, no done pulse; a subsequent 9/2 gives 4, 1.
REQ-036: Randomized sweep of all 8-bit x 4-bit operand pairs -> REQ-026 holds; the div_zero case follows REQ-014.

Source files
------------

// File: rtl/seq_divider_if.sv
//------------------------------------------------------------------------------
// Module : seq_divider_if
// Brief  : Request/result bundle between a divider client and seq_divider.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module : seq_divider
// Brief  : 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state_q,     state_d;
   logic [7:0] dvd_q,       dvd_d;
   logic [3:0] dvs_q,       dvs_d;
   logic [4:0] rem_q,       rem_d;
   logic [2:0] cnt_q,       cnt_d;
   logic [7:0] quotient_q,  quotient_d;
   logic [3:0] remainder_q, remainder_d;
   logic       div_zero_q,  div_zero_d;

   logic [5:0] w_shift;
   logic [5:0] w_trial;
   logic       w_qbit;
   logic [4:0] w_rem_next;

   // The dividend register doubles as the quotient accumulator: each step
   // shifts out the next dividend bit at the top and shifts in a quotient bit.
   assign w_shift    = {rem_q, dvd_q[7]};
   assign w_trial    = w_shift - {2'b00, dvs_q};
   assign w_qbit     = ~w_trial[5];
   assign w_rem_next = w_qbit ? w_trial[4:0] : w_shift[4:0];

   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor != 4'd0) begin
                  dvd_d   = bus.dividend;
                  dvs_d   = bus.divisor;
                  rem_d   = 5'd0;
                  cnt_d   = 3'd0;
                  state_d = CALC;
               end else begin
                  quotient_d  = 8'hFF;
                  remainder_d = 4'h0;
                  div_zero_d  = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         CALC: begin
            dvd_d = {dvd_q[6:0], w_qbit};
            rem_d = w_rem_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               quotient_d  = {dvd_q[6:0], w_qbit};
               remainder_d = w_rem_next[3:0];
               div_zero_d  = 1'b0;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dvd_q       <= 8'd0;
         dvs_q       <= 4'd0;
         rem_q       <= 5'd0;
         cnt_q       <= 3'd0;
         quotient_q  <= 8'd0;
         remainder_q <= 4'd0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign bus.busy      = (state_q == CALC);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module : tb_seq_divider
// Brief  : Self-checking bench for seq_divider (vectors, corner sequences, random).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   seq_divider_if dif ();

   seq_divider u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One complete operation; operands are scrambled while it runs.
   task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic dz, output int lat, output int bcnt,
                          output logic hold_ok, output logic done_after);
      logic [7:0] q0;
      logic [3:0] r0;
      logic       z0;
      logic       got;
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      q0 = dif.quotient;
      r0 = dif.remainder;
      z0 = dif.div_zero;
      lat = 0;
      bcnt = 0;
      hold_ok = 1'b1;
      got = 1'b0;
      while (!got && lat < 30) begin
         @(negedge clk);
         dif.start    = 1'b0;
         dif.dividend = 8'($urandom);
         dif.divisor  = 4'($urandom);
         lat++;
         if (dif.busy) bcnt++;
         if (dif.done) got = 1'b1;
         else if (dif.quotient != q0 || dif.remainder != r0 || dif.div_zero != z0)
            hold_ok = 1'b0;
      end
      q  = dif.quotient;
      r  = dif.remainder;
      dz = dif.div_zero;
      @(negedge clk);
      done_after = dif.done;
   endtask

   initial begin
      logic [7:0] q;
      logic [3:0] r;
      logic       dz, hold_ok, done_after, saw_done;
      int         lat, bcnt;
      int         ea, eb, eq, er;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      dif.start = 1'b0;
      dif.dividend = 8'd0;
      dif.divisor = 4'd0;

      vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
      vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
      vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
      vecs[3] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
      vecs[4] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1};
      vecs[5] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0};
      vecs[6] = '{8'd9,   4'd2,  8'd4,   4'd1, 1'b0};
      vecs[7] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1};
      vecs[8] = '{8'd50,  4'd3,  8'd16,  4'd2, 1'b0};
      vecs[9] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};

      #13;
      check("rst_busy", int'(dif.busy), 0);
      check("rst_done", int'(dif.done), 0);
      check("rst_quotient", int'(dif.quotient), 0);
      check("rst_remainder", int'(dif.remainder), 0);
      check("rst_div_zero", int'(dif.div_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].a, vecs[i].b, q, r, dz, lat, bcnt, hold_ok, done_after);
         check($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
         check($sformatf("vec%0d_div_zero", i), int'(dz), int'(vecs[i].dz));
         check($sformatf("vec%0d_latency", i), lat, vecs[i].dz ? 1 : 9);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].dz ? 0 : 8);
         check($sformatf("vec%0d_hold", i), int'(hold_ok), 1);
         check($sformatf("vec%0d_done_pulse", i), int'(done_after), 0);
      end

      // start held through CALC with new operands, then accepted right after done
      @(negedge clk);
      dif.start = 1'b1;
      dif.dividend = 8'd200;
      dif.divisor = 4'd7;
      @(negedge clk);
      dif.dividend = 8'd50;
      dif.divisor = 4'd3;
      lat = 1;
      while (!dif.done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("held_start_latency", lat, 9);
      check("held_start_quotient", int'(dif.quotient), 28);
      check("held_start_remainder", int'(dif.remainder), 4);
      @(negedge clk);
      check("b2b_idle_busy", int'(dif.busy), 0);
      @(negedge clk);
      dif.start = 1'b0;
      check("b2b_busy", int'(dif.busy), 1);
      check("b2b_quotient_hold", int'(dif.quotient), 28);
      lat = 1;
      while (!dif.done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", lat, 9);
      check("b2b_quotient", int'(dif.quotient), 16);
      check("b2b_remainder", int'(dif.remainder), 2);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      dif.start = 1'b1;
      dif.dividend = 8'd200;
      dif.divisor = 4'd7;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", int'(dif.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(dif.busy), 0);
      check("async_rst_done", int'(dif.done), 0);
      check("async_rst_quotient", int'(dif.quotient), 0);
      check("async_rst_remainder", int'(dif.remainder), 0);
      check("async_rst_div_zero", int'(dif.div_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (dif.done || dif.busy) saw_done = 1'b1;
      end
      check("abort_no_done", int'(saw_done), 0);
      run_div(8'd9, 4'd2, q, r, dz, lat, bcnt, hold_ok, done_after);
      check("post_rst_quotient", int'(q), 4);
      check("post_rst_remainder", int'(r), 1);
      check("post_rst_latency", lat, 9);

      // random sweep against plain arithmetic
      for (int n = 0; n < 300; n++) begin
         ea = int'($urandom_range(255, 0));
         eb = (n % 16 == 0) ? 0 : int'($urandom_range(15, 0));
         eq = (eb == 0) ? 255 : ea / eb;
         er = (eb == 0) ? 0 : ea % eb;
         run_div(8'(ea), 4'(eb), q, r, dz, lat, bcnt, hold_ok, done_after);
         check($sformatf("rnd%0d_%0d/%0d_quotient", n, ea, eb), int'(q), eq);
         check($sformatf("rnd%0d_%0d/%0d_remainder", n, ea, eb), int'(r), er);
         check($sformatf("rnd%0d_div_zero", n), int'(dz), (eb == 0) ? 1 : 0);
         check($sformatf("rnd%0d_latency", n), lat, (eb == 0) ? 1 : 9);
         if (eb != 0) begin
            check($sformatf("rnd%0d_identity", n), int'(q) * eb + int'(r), ea);
            check($sformatf("rnd%0d_rem_lt_div", n), int'(int'(r) < eb), 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
